// File: rtl/keypad_pkg.sv
// Shared keypad constants, key-code type and code helpers, used by the
// scanner and by the downstream 7-segment hit decoder.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam int         KP_ROWS  = 4;
  localparam int         KP_COLS  = 3;

  typedef logic [3:0] key_code_t;

  // Row r, column c maps to codes 1..12.
  function automatic key_code_t kp_code(input logic [1:0] r, input logic [1:0] c);
    return key_code_t'(4'(r) * 4'd3 + 4'(c) + 4'd1);
  endfunction

  // Lowest nonzero code of the two; KEY_NONE acts as "nothing seen".
  function automatic key_code_t kp_min(input key_code_t a, input key_code_t b);
    if (a == KEY_NONE) return b;
    if (b == KEY_NONE) return a;
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row lines.
// Resets to all-ones so an idle keypad reads as "no row pulled low".
module row_sync
  import keypad_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] row_i,
  output logic [KP_ROWS-1:0] row_o
);

  logic [KP_ROWS-1:0] meta_q;
  logic [KP_ROWS-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column scan, per-frame lowest-code reduction, frame
// debounce and registered key code / press strobe. Optional auto-repeat is
// enabled by defining KEYPAD_SCANNER_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 4,
  parameter int DEBOUNCE_CNT  = 3,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] row_in,
  output logic [KP_COLS-1:0] col_out,
  output logic [3:0]         key_code,
  output logic               key_valid
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int STB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0]  STB_MAX   = STB_W'(DEBOUNCE_CNT);

  // Sampling on the last slot cycle relies on the 2-cycle synchroniser delay.
  if (SCAN_DIV < 4) begin : g_chk_div
    $error("keypad_scanner: SCAN_DIV must be 4 or more");
  end
  if (DEBOUNCE_CNT < 1) begin : g_chk_deb
    $error("keypad_scanner: DEBOUNCE_CNT must be 1 or more");
  end
  if (REPEAT_FRAMES < 1) begin : g_chk_rep
    $error("keypad_scanner: REPEAT_FRAMES must be 1 or more");
  end

  logic [KP_ROWS-1:0] row_s;

  row_sync u_row_sync (
    .clk   (clk),
    .rst   (rst),
    .row_i (row_in),
    .row_o (row_s)
  );

  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [1:0]         col_q, col_d;
  logic [KP_COLS-1:0] col_out_q, col_out_d;
  key_code_t          frame_min_q, frame_min_d;
  key_code_t          cand_q, cand_d;
  logic [STB_W-1:0]   stable_q, stable_d;
  key_code_t          key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;

  logic      slot_last;
  logic      frame_end;
  logic      accept;
  key_code_t slot_code;
  key_code_t frame_res;

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  assign slot_last = (slot_q == SLOT_LAST);
  assign frame_end = slot_last && (col_q == 2'd2);

  // Lowest pressed row in the driven column wins.
  always_comb begin
    slot_code = KEY_NONE;
    for (int r = KP_ROWS - 1; r >= 0; r--) begin
      if (!row_s[r]) slot_code = kp_code(2'(r), col_q);
    end
  end

  assign frame_res = kp_min(frame_min_q, slot_code);

  always_comb begin
    slot_d      = slot_last ? '0 : slot_q + 1'b1;
    col_d       = col_q;
    if (slot_last) col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    col_out_d   = ~(3'b001 << col_d);

    frame_min_d = frame_min_q;
    if (frame_end)      frame_min_d = KEY_NONE;
    else if (slot_last) frame_min_d = frame_res;

    cand_d      = cand_q;
    stable_d    = stable_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    accept      = 1'b0;

    if (frame_end) begin
      if (frame_res == cand_q) begin
        stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + 1'b1;
      end else begin
        cand_d   = frame_res;
        stable_d = STB_W'(1);
      end
      if (stable_d == STB_MAX && cand_d != key_code_q) begin
        accept      = 1'b1;
        key_code_d  = cand_d;
        key_valid_d = (cand_d != KEY_NONE);
      end
    end

`ifdef KEYPAD_SCANNER_REPEAT_EN
    rep_d = rep_q;
    if (frame_end) begin
      if (!accept && key_code_q != KEY_NONE && frame_res == key_code_q) begin
        if (rep_q == REP_LAST) begin
          rep_d       = '0;
          key_valid_d = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end else begin
        rep_d = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      col_q       <= 2'd0;
      col_out_q   <= 3'b110;
      frame_min_q <= KEY_NONE;
      cand_q      <= KEY_NONE;
      stable_q    <= '0;
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      slot_q      <= slot_d;
      col_q       <= col_d;
      col_out_q   <= col_out_d;
      frame_min_q <= frame_min_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule
